uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART_Tx serialiser between C_NUM_REQ word requesters. Round-robin grant.
//  Drives the UART send/busy handshake: send is held until busy rises, then dropped.
//  Supervises each transfer with a timeout. Sits between on-chip data sources and UART_Tx.
// PARAMETERS
//  C_NUM_REQ          4     number of requesters, 2..8
//  C_UART_DATA_WIDTH  8     word width [bit], same value as UART_Tx
//  C_SEND_TIMEOUT     64    clk cycles allowed for tx_busy to rise after tx_send asserts
// PORTS
//  clk        in   1          system clock, all logic on rising edge
//  rstb       in   1          asynchronous reset, active-low
//  req_valid  in   N          requester i has a word ready; held until req_ack[i]
//  req_data   in   N*W        word of requester i at req_data[i*W +: W]
//  req_ack    out  N          one-cycle pulse: word of requester i accepted
//  grant_id   out  clog2(N)   index of the last accepted requester
//  tx_data    out  W          to UART_Tx data
//  tx_send    out  1          to UART_Tx send
//  tx_busy    in   1          from UART_Tx busy
//  tx_error   in   1          from UART_Tx error
//  busy       out  1          arbiter not in IDLE
//  err        out  1          sticky: tx_error seen, or timeout
//  timeout    out  1          sticky: tx_busy did not rise within C_SEND_TIMEOUT
//  err_clr    in   1          synchronous clear of err and timeout
// BEHAVIOUR
//  Reset values:
//   - all outputs 0; state IDLE; RR pointer 0; timeout counter 0.
//   - Async assertion drops tx_send immediately.
//  FSM IDLE -> SEND -> DRAIN -> IDLE:
//   - IDLE: if tx_busy==0 and |req_valid, pick the first valid index starting at the pointer.
//     On that edge latch tx_data and grant_id, set tx_send=1, pulse req_ack[win] for 1 cycle,
//     set pointer=(win+1)%N, clear counter, go to SEND. Latency: valid sampled at edge k ->
//     ack and send visible after edge k.
//   - IDLE with tx_busy==1: wait. No grant is issued.
//   - SEND: tx_send=1 and tx_data held stable. Counter increments each cycle.
//       tx_busy==1: tx_send=0, go to DRAIN.
//       counter==C_SEND_TIMEOUT-1 without busy: tx_send=0, timeout=1, err=1, go to IDLE.
//   - DRAIN: wait for tx_busy==0, then go to IDLE. tx_data held.
//  Handshake and ordering:
//   - A requester may change req_data only after its ack. Dropping valid before grant is
//     allowed and has no effect.
//   - All N valid together: served in pointer order, one word per UART frame.
//     A lone requester is served back-to-back.
//  Errors:
//   - tx_error==1 in any state sets err (sticky).
//   - err_clr and a new error on the same edge: the set wins.
// CONFIGURATION
//  UART_ARB_PRIO_EN defined:
//   - requester 0 has strict priority. It is granted whenever req_valid[0]=1 in IDLE.
//   - The others stay round-robin. The pointer is not advanced by a grant to requester 0.
//  UART_ARB_PRIO_EN undefined: pure round-robin over all N requesters.
// STRUCTURE
//  Package uart_pkg:
//   - typedef enum logic [1:0] {ARB_IDLE, ARB_SEND, ARB_DRAIN} arb_state_t.
//   - function clog2-based widths.
//   - constant C_UART_DATA_WIDTH default.
//  Sub-module rr_picker (combinational):
//   - in: req vector and pointer. out: winner index and any.
//   - Priority override logic stays in the top.
// TESTING
//  1. Reset: rstb low mid-SEND -> tx_send=0 at once. All outputs 0 until first grant after release.
//  2. Single word: req_valid=0001, data 0xA5.
//     -> req_ack=0001 one cycle; tx_data=0xA5; tx_send held until busy; grant_id=0.
//  3. All valid (1111), data 0x11/0x22/0x33/0x44, pointer 2.
//     -> ack order 2,3,0,1; one grant per busy fall.
//  4. Timeout: tx_busy stuck 0 -> tx_send drops after 64 cycles; timeout=err=1.
//     err_clr -> both 0.
//  5. tx_error pulse during DRAIN -> err=1, timeout=0. Next grant proceeds normally.
//  6. UART_ARB_PRIO_EN: req0 re-asserted every frame with req1..3 valid
//     -> req0 wins each IDLE; without macro, req1..3 are served in between.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared types, default widths and width helpers for the UART transmit arbiter
package uart_tx_arbiter_pkg;
  localparam int C_UART_DATA_WIDTH_DEF = 8;
  localparam int C_NUM_REQ_DEF         = 4;
  localparam int C_SEND_TIMEOUT_DEF    = 64;
  typedef enum logic [1:0] {ARB_IDLE, ARB_SEND, ARB_DRAIN} arb_state_t;
  function automatic int f_idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  function automatic int f_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester bus, UART_Tx handshake and status bundle of the arbiter
//  slave  : arbiter side (consumes req_valid/req_data/tx_busy/tx_error/err_clr,
//           drives req_ack/grant_id/tx_data/tx_send/busy/err/timeout)
//  master : requester/UART/system side, mirror image of slave
interface uart_tx_arbiter_if
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N = C_NUM_REQ_DEF,
  parameter int W = C_UART_DATA_WIDTH_DEF
);
  localparam int IW = f_idx_w(N);
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ack;
  logic [IW-1:0]  grant_id;
  logic [W-1:0]   tx_data;
  logic           tx_send;
  logic           tx_busy;
  logic           tx_error;
  logic           busy;
  logic           err;
  logic           timeout;
  logic           err_clr;
  modport slave (
    input  req_valid, req_data, tx_busy, tx_error, err_clr,
    output req_ack, grant_id, tx_data, tx_send, busy, err, timeout
  );
  modport master (
    output req_valid, req_data, tx_busy, tx_error, err_clr,
    input  req_ack, grant_id, tx_data, tx_send, busy, err, timeout
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search, first set request at or after the pointer
//  i_req : request vector
//  i_ptr : index where the search starts
//  o_win : winning index (0 when nothing requests)
//  o_any : at least one request set
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_win,
  output logic          o_any
);
  logic [N-1:0] w_rot;
  // rotate so that bit 0 is the requester the pointer names
  assign w_rot = N'({i_req, i_req} >> i_ptr);
  assign o_any = |i_req;
  always_comb begin
    o_win = '0;
    for (int k = N - 1; k >= 0; k--)
      if (w_rot[k]) o_win = IW'((int'(i_ptr) + k) % N);
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART_Tx between C_NUM_REQ requesters with round-robin grant and send timeout
//  clk  : system clock, rising edge
//  rstb : asynchronous active-low reset
//  bus  : uart_tx_arbiter_if.slave (requester valid/data/ack, grant_id, tx_data/send/busy/error,
//         busy, sticky err/timeout, err_clr)
//  Build option UART_ARB_PRIO_EN: requester 0 gets strict priority, the rest stay round-robin.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int C_NUM_REQ         = C_NUM_REQ_DEF,
  parameter int C_UART_DATA_WIDTH = C_UART_DATA_WIDTH_DEF,
  parameter int C_SEND_TIMEOUT    = C_SEND_TIMEOUT_DEF
) (
  input logic              clk,
  input logic              rstb,
  uart_tx_arbiter_if.slave bus
);
  localparam int IW = f_idx_w(C_NUM_REQ);
  localparam int CW = f_cnt_w(C_SEND_TIMEOUT);
  arb_state_t                   r_state, w_next;
  logic [IW-1:0]                r_ptr, r_gid, w_win, w_rr_win, w_ptr_next;
  logic [CW-1:0]                r_cnt;
  logic [C_UART_DATA_WIDTH-1:0] r_data;
  logic [C_NUM_REQ-1:0]         r_ack, w_pick_req;
  logic                         r_err, r_tmo;
  logic                         w_rr_any, w_any, w_adv, w_grant, w_tmo;
`ifdef UART_ARB_PRIO_EN
  // requester 0 bypasses the rotation and leaves the pointer where it was
  assign w_pick_req = bus.req_valid & ~C_NUM_REQ'(1);
  assign w_win      = bus.req_valid[0] ? '0 : w_rr_win;
  assign w_any      = bus.req_valid[0] | w_rr_any;
  assign w_adv      = !bus.req_valid[0];
`else
  assign w_pick_req = bus.req_valid;
  assign w_win      = w_rr_win;
  assign w_any      = w_rr_any;
  assign w_adv      = 1'b1;
`endif
  rr_picker #(.N(C_NUM_REQ), .IW(IW)) u_pick (
    .i_req (w_pick_req),
    .i_ptr (r_ptr),
    .o_win (w_rr_win),
    .o_any (w_rr_any)
  );
  assign w_ptr_next = (w_win == IW'(C_NUM_REQ - 1)) ? '0 : w_win + IW'(1);
  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    w_tmo   = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        w_grant = !bus.tx_busy && w_any;
        w_next  = w_grant ? ARB_SEND : ARB_IDLE;
      end
      ARB_SEND: begin
        w_tmo  = !bus.tx_busy && (r_cnt == CW'(C_SEND_TIMEOUT - 1));
        w_next = bus.tx_busy ? ARB_DRAIN : (w_tmo ? ARB_IDLE : ARB_SEND);
      end
      ARB_DRAIN: w_next = bus.tx_busy ? ARB_DRAIN : ARB_IDLE;
      default:   w_next = ARB_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) r_state <= ARB_IDLE;
    else       r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_ptr  <= '0;
      r_gid  <= '0;
      r_cnt  <= '0;
      r_data <= '0;
      r_ack  <= '0;
      r_err  <= 1'b0;
      r_tmo  <= 1'b0;
    end else begin
      r_ack <= w_grant ? C_NUM_REQ'(1) << w_win : '0;
      if (w_grant) begin
        r_data <= bus.req_data[int'(w_win) * C_UART_DATA_WIDTH +: C_UART_DATA_WIDTH];
        r_gid  <= w_win;
        r_cnt  <= '0;
        if (w_adv) r_ptr <= w_ptr_next;
      end else if (r_state == ARB_SEND) begin
        r_cnt <= r_cnt + CW'(1);
      end
      // a new error on the clearing edge survives the clear
      r_err <= bus.tx_error | w_tmo | (r_err & !bus.err_clr);
      r_tmo <= w_tmo | (r_tmo & !bus.err_clr);
    end
  end
  // tx_send is decoded from the state so an asynchronous reset drops it at once
  assign bus.tx_send  = (r_state == ARB_SEND);
  assign bus.busy     = (r_state != ARB_IDLE);
  assign bus.tx_data  = r_data;
  assign bus.grant_id = r_gid;
  assign bus.req_ack  = r_ack;
  assign bus.err      = r_err;
  assign bus.timeout  = r_tmo;
endmodule
